mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  N-channel memory front-end: arbitrates fetch/load/store clients onto one single-port memory
//  (1-cycle read latency, 1-cycle write, no byte enables). Adds byte/half access with sign
//  extension, read-modify-write for sub-word stores, misalignment errors, RR or fixed priority.
//  Sits between i_fetch/LS units and the external memory port in the cpu top.
// PARAMETERS
//  NUM_CH      2   number of client channels (>=1); channel index width CH_W = max(1,$clog2(NUM_CH))
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  word width (fixed 32; sub-word logic assumes 4 bytes)
//  FIXED_PRIO  0   0 = round-robin, 1 = fixed priority (ch0 highest)
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   async reset, active-high
//  req_valid  in   NUM_CH              per-channel request; held stable until that channel's done
//  req_we     in   NUM_CH              1 = store, 0 = load
//  req_size   in   2*NUM_CH            00 byte, 01 half, 10 word (11 -> error)
//  req_signed in   NUM_CH              load sign-extends sub-word data when 1
//  req_addr   in   ADDR_WIDTH*NUM_CH   byte address
//  req_wdata  in   DATA_WIDTH*NUM_CH   store data, value in low bits
//  resp_done  out  NUM_CH              one-cycle completion pulse for the owning channel
//  resp_err   out  1                   misaligned/illegal size; valid only with resp_done
//  resp_data  out  DATA_WIDTH          load result; valid only with resp_done
//  mem_addr   out  ADDR_WIDTH          word-aligned byte address (low 2 bits 0)
//  mem_we     out  1                   write strobe
//  mem_src    out  DATA_WIDTH          write data
//  mem_data   in   DATA_WIDTH          read data, valid the cycle after mem_addr presented
// BEHAVIOUR
//  Reset: state IDLE, resp_done=0, resp_err=0, resp_data=0, mem_we=0, mem_addr=0, mem_src=0,
//   RR pointer = NUM_CH-1 (ch0 wins first). Async rst mid-access abandons it; mem_we drops at once.
//  FSM states: IDLE, ACCESS, WAIT, WRITE, DONE. One request in flight at a time.
//  IDLE: if any req_valid: grant one, latch ch/we/size/signed/addr/wdata -> ACCESS.
//   Alignment check at grant: half needs addr[0]=0, word needs addr[1:0]=0, size 11 illegal;
//   failure -> DONE with err=1, no memory access.
//  ACCESS: mem_addr={addr[AW-1:2],2'b00}. Word store: mem_we=1, mem_src=wdata -> DONE.
//   Load or sub-word store -> WAIT.
//  WAIT: mem_data valid. Load: select byte/half by addr[1:0], zero/sign-extend, register
//   -> DONE. Sub-word store: merge wdata lanes into mem_data -> WRITE.
//  WRITE: mem_we=1, mem_addr held, mem_src=merged word -> DONE.
//  DONE: resp_done[ch]=1 for exactly one cycle with resp_data/resp_err -> IDLE.
//  Latency (valid seen in IDLE at T0 to done): word store 2, load 3, sub-word store 4, error 1.
//  Client drops valid the cycle after done; valid still high in IDLE = new request.
//  Arbitration: RR searches from pointer+1 with wrap (NUM_CH-1 -> 0); pointer updates to granted
//   ch on grant only. FIXED_PRIO=1: lowest index wins, pointer unused.
//  Requests arriving while busy wait; no starvation in RR. Store merge uses only addressed lanes.
//  mem_addr/mem_src are 0 outside ACCESS/WAIT/WRITE; mem_we high only in ACCESS(word) and WRITE.
// STRUCTURE
//  Package mem_arb_pkg: size encodings (SZ_B/SZ_H/SZ_W), FSM state encoding, lane-select/extend
//   function. Sub-module rr_arbiter (NUM_CH, FIXED_PRIO; req vector -> one-hot grant + index,
//   pointer update on accept). Datapath and FSM in this module.
// TESTING
//  1 ch0 load word @0x100, mem=0xDEADBEEF -> done[0] 3 cycles later, data 0xDEADBEEF, err 0.
//  2 ch1 signed load byte @0x103, word 0x80FF1234 -> data 0xFFFFFF80; unsigned -> 0x00000080.
//  3 ch0 store half 0xABCD @0x202, old word 0x11223344 -> WRITE writes 0xABCD3344, done at +4.
//  4 ch0+ch1 valid every cycle (NUM_CH=2, RR) -> grants alternate 0,1,0,1; FIXED_PRIO=1 -> ch1
//    wins only when ch0 idle.
//  5 load word @0x102 -> done at +1, err=1, mem_we never high, mem_addr stays 0.
//  6 rst asserted in WRITE -> mem_we 0 immediately, no done pulse, next grant starts from ch0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and lane helpers for the memory arbiter.
// Helpers assume a 32-bit word with four byte lanes.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    lane_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    lane_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

    // Only the addressed lanes of the old word are replaced; upper wdata bits are ignored.
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        mask = (size == SZ_B) ? 32'h0000_00FF : (size == SZ_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mask = mask << {off, 3'b000};
        lane_merge = (old & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority request picker with a registered last-grant pointer.
// The pointer only moves when the caller accepts a grant.
module rr_arbiter #(
    parameter int NUM_CH     = 2,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    logic [CH_W-1:0] ptr_q;

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        int c;
        c     = 0;
        idx_o = '0;
        if (FIXED_PRIO) begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (req_i[i]) idx_o = CH_W'(i);
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                c = int'(ptr_q) + k;
                if (c >= NUM_CH) c = c - NUM_CH;
                if (req_i[c]) idx_o = CH_W'(c);
            end
        end
    end

    assign any_o   = |req_i;
    assign grant_o = any_o ? (NUM_CH'(1) << idx_o) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= CH_W'(NUM_CH - 1);
        else if (accept_i && any_o && !FIXED_PRIO)
            ptr_q <= idx_o;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel load/store front-end for a single-port memory with 1-cycle read latency.
// Sub-word loads are extended, sub-word stores are done as read-modify-write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [2*NUM_CH-1:0]          req_size,
    input  logic [NUM_CH-1:0]            req_signed,
    input  logic [ADDR_WIDTH*NUM_CH-1:0] req_addr,
    input  logic [DATA_WIDTH*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]            resp_done,
    output logic                         resp_err,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_src,
    input  logic [DATA_WIDTH-1:0]        mem_data
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                  state_q;
    logic [CH_W-1:0]         ch_q;
    logic                    we_q;
    logic                    sgn_q;
    logic [1:0]              size_q;
    logic [1:0]              off_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_CH-1:0]       done_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   maddr_q;
    logic                    mwe_q;
    logic [DATA_WIDTH-1:0]   msrc_q;

    logic [NUM_CH-1:0]       gnt;
    logic [CH_W-1:0]         gnt_idx;
    logic                    gnt_any;
    logic                    g_we;
    logic                    g_sgn;
    logic [1:0]              g_size;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [NUM_CH-1:0]       ch_onehot;

    rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIXED_PRIO (FIXED_PRIO),
        .CH_W       (CH_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .accept_i (state_q == ST_IDLE),
        .grant_o  (gnt),
        .idx_o    (gnt_idx),
        .any_o    (gnt_any)
    );

    assign g_we      = req_we[gnt_idx];
    assign g_sgn     = req_signed[gnt_idx];
    assign g_size    = req_size[2*gnt_idx +: 2];
    assign g_addr    = req_addr[ADDR_WIDTH*gnt_idx +: ADDR_WIDTH];
    assign g_wdata   = req_wdata[DATA_WIDTH*gnt_idx +: DATA_WIDTH];
    assign ch_onehot = NUM_CH'(1) << ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            wdata_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            maddr_q <= '0;
            mwe_q   <= 1'b0;
            msrc_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        ch_q    <= gnt_idx;
                        we_q    <= g_we;
                        sgn_q   <= g_sgn;
                        size_q  <= g_size;
                        off_q   <= g_addr[1:0];
                        wdata_q <= g_wdata;
                        if (misaligned(g_size, g_addr[1:0])) begin
                            done_q  <= gnt;
                            err_q   <= 1'b1;
                            data_q  <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            maddr_q <= {g_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (g_we && g_size == SZ_W) begin
                                mwe_q  <= 1'b1;
                                msrc_q <= g_wdata;
                            end
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (we_q && size_q == SZ_W) begin
                        mwe_q   <= 1'b0;
                        msrc_q  <= '0;
                        maddr_q <= '0;
                        done_q  <= ch_onehot;
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (we_q) begin
                        mwe_q   <= 1'b1;
                        msrc_q  <= lane_merge(mem_data, wdata_q, off_q, size_q);
                        state_q <= ST_WRITE;
                    end else begin
                        data_q  <= lane_extract(mem_data, off_q, size_q, sgn_q);
                        err_q   <= 1'b0;
                        done_q  <= ch_onehot;
                        maddr_q <= '0;
                        state_q <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    mwe_q   <= 1'b0;
                    msrc_q  <= '0;
                    maddr_q <= '0;
                    done_q  <= ch_onehot;
                    err_q   <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    data_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_done = done_q;
    assign resp_err  = err_q;
    assign resp_data = data_q;
    assign mem_addr  = maddr_q;
    assign mem_we    = mwe_q;
    assign mem_src   = msrc_q;

endmodule
